// File: rtl/writeback_sel.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_sel
//  Description : Selects one of NUM_SRC writeback sources by index, waits up
//                to TIMEOUT cycles for it to become valid, and presents the
//                captured value with a one-cycle writeback strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module writeback_sel #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 4,   // 2**SEL_W must cover NUM_SRC
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SEL_W-1:0]          req_sel,
  input  logic [4:0]                req_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic                      wb_valid,
  output logic [DATA_W-1:0]         wb_data,
  output logic [4:0]                wb_rd,
  output logic                      err_badsel,
  output logic                      err_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // One extra bit so NUM_SRC == 2**SEL_W is still representable
  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W+1)'(NUM_SRC);
  localparam logic [7:0]     TO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0]        state_q,   state_d;
  logic [7:0]        cnt_q,     cnt_d;
  logic [SEL_W-1:0]  sel_q,     sel_d;
  logic [4:0]        rd_q,      rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q,   wb_rd_d;
  logic              badsel_q,  badsel_d;
  logic              timeout_q, timeout_d;
  logic              rdy_en_q;

  logic [SEL_W-1:0]  w_mux_sel;
  logic              w_sel_ok;
  logic              w_src_hit;
  logic [DATA_W-1:0] w_src_data;
  logic              w_accept;

  // Source mux: IDLE looks at the incoming select, WAIT at the captured one
  always_comb begin
    w_mux_sel  = (state_q == S_IDLE) ? req_sel : sel_q;
    w_sel_ok   = ({1'b0, w_mux_sel} < NUM_SRC_W);
    w_src_hit  = 1'b0;
    w_src_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_mux_sel == SEL_W'(i)) begin
        w_src_hit  = src_valid[i];
        w_src_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath-update logic; flush overrides every transition
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    badsel_d  = 1'b0;
    timeout_d = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            sel_d = req_sel;
            rd_d  = req_rd;
            if (!w_sel_ok) begin
              badsel_d = 1'b1;
            end else if (w_src_hit) begin
              wb_data_d = w_src_data;
              wb_rd_d   = req_rd;
              state_d   = S_OUT;
            end else begin
              cnt_d   = 8'd0;
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A valid source wins over an expiring counter in the same cycle
          if (w_src_hit) begin
            wb_data_d = w_src_data;
            wb_rd_d   = rd_q;
            state_d   = S_OUT;
          end else if (cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            cnt_d     = 8'd0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_OUT: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM outputs; the strobe is suppressed by a flush in the OUT cycle
  always_comb begin
    req_ready = (state_q == S_IDLE) && !flush && rdy_en_q;
    wb_valid  = (state_q == S_OUT) && !flush;
    w_accept  = req_valid && req_ready;
  end

  // Datapath and pulse registers; rdy_en_q holds ready low until the first edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= 8'd0;
      sel_q     <= '0;
      rd_q      <= 5'd0;
      wb_data_q <= '0;
      wb_rd_q   <= 5'd0;
      badsel_q  <= 1'b0;
      timeout_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      badsel_q  <= badsel_d;
      timeout_q <= timeout_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign err_badsel  = badsel_q;
  assign err_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_sel
//  Description : Directed self-checking bench for writeback_sel. A default
//                instance (8 sources, TIMEOUT 64) and a small instance
//                (6 sources, SEL_W 3, TIMEOUT 4) are exercised.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_sel;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;

  // default instance
  logic         req_valid, req_ready;
  logic [3:0]   req_sel;
  logic [4:0]   req_rd;
  logic [255:0] src_data;
  logic [7:0]   src_valid;
  logic         wb_valid, err_badsel, err_timeout;
  logic [31:0]  wb_data;
  logic [4:0]   wb_rd;

  // small instance
  logic         s_req_valid, s_req_ready;
  logic [2:0]   s_req_sel;
  logic [4:0]   s_req_rd;
  logic [191:0] s_src_data;
  logic [5:0]   s_src_valid;
  logic         s_wb_valid, s_err_badsel, s_err_timeout;
  logic [31:0]  s_wb_data;
  logic [4:0]   s_wb_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_sel u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_rd(req_rd), .src_data(src_data), .src_valid(src_valid),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .err_badsel(err_badsel), .err_timeout(err_timeout)
  );

  writeback_sel #(.DATA_W(32), .NUM_SRC(6), .SEL_W(3), .TIMEOUT(4)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .flush(1'b0),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_sel(s_req_sel),
    .req_rd(s_req_rd), .src_data(s_src_data), .src_valid(s_src_valid),
    .wb_valid(s_wb_valid), .wb_data(s_wb_data), .wb_rd(s_wb_rd),
    .err_badsel(s_err_badsel), .err_timeout(s_err_timeout)
  );

  // status vectors: {wb_valid, req_ready, err_badsel, err_timeout}
  wire [3:0] st   = {wb_valid, req_ready, err_badsel, err_timeout};
  wire [3:0] s_st = {s_wb_valid, s_req_ready, s_err_badsel, s_err_timeout};

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; flush = 1'b0;
    req_valid = 1'b0; req_sel = '0; req_rd = '0; src_valid = '0;
    s_req_valid = 1'b0; s_req_sel = '0; s_req_rd = '0; s_src_valid = '0;
    for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = 32'h5A5A_0000 | i;
    for (int i = 0; i < 6; i++) s_src_data[i*32 +: 32] = 32'h3C3C_0000 | i;
    cyc(); cyc();
    #1;
    checks++;
    if ({st, wb_data, wb_rd} !== {4'b0000, 32'h0, 5'h0}) begin
      errors++; $display("FAIL reset_state: got st=%b data=%h rd=%0d, want 0000/0/0", st, wb_data, wb_rd);
    end
    checks++;
    if ({s_st, s_wb_data, s_wb_rd} !== {4'b0000, 32'h0, 5'h0}) begin
      errors++; $display("FAIL reset_state_s: got st=%b data=%h rd=%0d, want 0000/0/0", s_st, s_wb_data, s_wb_rd);
    end
    cyc(); reset_n = 1'b1; #1;
    checks++;
    if ({req_ready, s_req_ready} !== 2'b00) begin
      errors++; $display("FAIL ready_before_edge: got %b, want 00", {req_ready, s_req_ready});
    end
    cyc(); #1;
    checks++;
    if ({st, s_st} !== {4'b0100, 4'b0100}) begin
      errors++; $display("FAIL ready_after_edge: got %b/%b, want 0100/0100", st, s_st);
    end
  endtask

  task automatic test_immediate;
    cyc(); req_valid = 1'b1; req_sel = 4'd3; req_rd = 5'd9; src_valid = 8'h08;
    src_data[3*32 +: 32] = 32'hDEADBEEF; #1;
    checks++;
    if (st !== 4'b0100) begin errors++; $display("FAIL imm_accept: got %b, want 0100", st); end
    cyc(); req_valid = 1'b0; src_valid = 8'h00; #1;
    checks++;
    if ({st, wb_data, wb_rd} !== {4'b1000, 32'hDEADBEEF, 5'd9}) begin
      errors++; $display("FAIL imm_wb: got st=%b data=%h rd=%0d, want 1000/deadbeef/9", st, wb_data, wb_rd);
    end
    cyc(); #1;
    checks++;
    if ({st, wb_data} !== {4'b0100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL imm_after: got st=%b data=%h, want 0100/deadbeef", st, wb_data);
    end
  endtask

  task automatic test_wait;
    cyc(); req_valid = 1'b1; req_sel = 4'd2; req_rd = 5'd5; src_valid = 8'hFB;
    src_data[2*32 +: 32] = 32'hFFFF_0000; #1;
    checks++;
    if (st !== 4'b0100) begin errors++; $display("FAIL wait_accept: got %b, want 0100", st); end
    for (int k = 1; k <= 5; k++) begin
      cyc(); req_valid = 1'b1; req_sel = 4'd0; req_rd = 5'd1; #1;
      checks++;
      if (st !== 4'b0000) begin errors++; $display("FAIL wait_cycle%0d: got %b, want 0000", k, st); end
    end
    cyc(); req_valid = 1'b0; src_valid = 8'h04; src_data[2*32 +: 32] = 32'h0000_0007; #1;
    checks++;
    if (st !== 4'b0000) begin errors++; $display("FAIL wait_srcrise: got %b, want 0000", st); end
    cyc(); src_valid = 8'h00; #1;
    checks++;
    if ({st, wb_data, wb_rd} !== {4'b1000, 32'h7, 5'd5}) begin
      errors++; $display("FAIL wait_wb: got st=%b data=%h rd=%0d, want 1000/7/5", st, wb_data, wb_rd);
    end
    cyc(); #1;
    checks++;
    if (st !== 4'b0100) begin errors++; $display("FAIL wait_after: got %b, want 0100", st); end
  endtask

  task automatic test_timeout;
    cyc(); s_req_valid = 1'b1; s_req_sel = 3'd1; s_req_rd = 5'd12; s_src_valid = 6'h3D; #1;
    checks++;
    if (s_st !== 4'b0100) begin errors++; $display("FAIL to_accept: got %b, want 0100", s_st); end
    for (int k = 1; k <= 4; k++) begin
      cyc(); s_req_valid = 1'b0; #1;
      checks++;
      if (s_st !== 4'b0000) begin errors++; $display("FAIL to_wait%0d: got %b, want 0000", k, s_st); end
    end
    cyc(); #1;
    checks++;
    if (s_st !== 4'b0101) begin errors++; $display("FAIL to_pulse: got %b, want 0101", s_st); end
    cyc(); s_src_valid = 6'h00; #1;
    checks++;
    if (s_st !== 4'b0100) begin errors++; $display("FAIL to_after: got %b, want 0100", s_st); end
  endtask

  task automatic test_priority;
    cyc(); s_req_valid = 1'b1; s_req_sel = 3'd4; s_req_rd = 5'd3; s_src_valid = 6'h00; #1;
    checks++;
    if (s_st !== 4'b0100) begin errors++; $display("FAIL prio_accept: got %b, want 0100", s_st); end
    for (int k = 1; k <= 3; k++) begin
      cyc(); s_req_valid = 1'b0; #1;
    end
    cyc(); s_src_valid = 6'h10; s_src_data[4*32 +: 32] = 32'hA5A5_0F0F; #1;
    checks++;
    if (s_st !== 4'b0000) begin errors++; $display("FAIL prio_last_wait: got %b, want 0000", s_st); end
    cyc(); s_src_valid = 6'h00; #1;
    checks++;
    if ({s_st, s_wb_data, s_wb_rd} !== {4'b1000, 32'hA5A5_0F0F, 5'd3}) begin
      errors++; $display("FAIL prio_wb: got st=%b data=%h rd=%0d, want 1000/a5a50f0f/3", s_st, s_wb_data, s_wb_rd);
    end
    cyc(); #1;
    checks++;
    if (s_st !== 4'b0100) begin errors++; $display("FAIL prio_after: got %b, want 0100", s_st); end
  endtask

  task automatic test_badsel;
    logic [2:0] bad [2];
    bad[0] = 3'd7; bad[1] = 3'd6;
    for (int j = 0; j < 2; j++) begin
      cyc(); s_req_valid = 1'b1; s_req_sel = bad[j]; s_req_rd = 5'd1; s_src_valid = 6'h3F; #1;
      cyc(); s_req_valid = 1'b0; #1;
      checks++;
      if ({s_st, s_wb_data, s_wb_rd} !== {4'b0110, 32'hA5A5_0F0F, 5'd3}) begin
        errors++; $display("FAIL badsel_%0d: got st=%b data=%h rd=%0d, want 0110/a5a50f0f/3", bad[j], s_st, s_wb_data, s_wb_rd);
      end
      cyc(); #1;
      checks++;
      if (s_st !== 4'b0100) begin errors++; $display("FAIL badsel_after_%0d: got %b, want 0100", bad[j], s_st); end
    end
    cyc(); s_req_valid = 1'b1; s_req_sel = 3'd5; s_req_rd = 5'd2; s_src_valid = 6'h20;
    s_src_data[5*32 +: 32] = 32'h8000_0001; #1;
    cyc(); s_req_valid = 1'b0; s_src_valid = 6'h00; #1;
    checks++;
    if ({s_st, s_wb_data, s_wb_rd} !== {4'b1000, 32'h8000_0001, 5'd2}) begin
      errors++; $display("FAIL lastsrc_wb: got st=%b data=%h rd=%0d, want 1000/80000001/2", s_st, s_wb_data, s_wb_rd);
    end
  endtask

  task automatic test_flush;
    cyc(); req_valid = 1'b1; req_sel = 4'd1; req_rd = 5'd20; src_valid = 8'h00; #1;
    cyc(); req_valid = 1'b0; flush = 1'b1; #1;
    checks++;
    if (st !== 4'b0000) begin errors++; $display("FAIL flush_wait: got %b, want 0000", st); end
    cyc(); flush = 1'b0; src_valid = 8'h02; src_data[1*32 +: 32] = 32'hCAFE_F00D; #1;
    checks++;
    if (st !== 4'b0100) begin errors++; $display("FAIL flush_wait_next: got %b, want 0100", st); end
    cyc(); src_valid = 8'h00; #1;
    checks++;
    if ({st, wb_data, wb_rd} !== {4'b0100, 32'h7, 5'd5}) begin
      errors++; $display("FAIL flush_wait_hold: got st=%b data=%h rd=%0d, want 0100/7/5", st, wb_data, wb_rd);
    end
    cyc(); req_valid = 1'b1; req_sel = 4'd1; req_rd = 5'd21; src_valid = 8'h02;
    src_data[1*32 +: 32] = 32'h1234_5678; #1;
    cyc(); req_valid = 1'b0; src_valid = 8'h00; flush = 1'b1; #1;
    checks++;
    if (st !== 4'b0000) begin errors++; $display("FAIL flush_out: got %b, want 0000", st); end
    cyc(); flush = 1'b0; #1;
    checks++;
    if ({st, wb_data, wb_rd} !== {4'b0100, 32'h1234_5678, 5'd21}) begin
      errors++; $display("FAIL flush_out_next: got st=%b data=%h rd=%0d, want 0100/12345678/21", st, wb_data, wb_rd);
    end
  endtask

  task automatic test_reset_mid;
    cyc(); req_valid = 1'b1; req_sel = 4'd5; req_rd = 5'd30; src_valid = 8'h00; #1;
    cyc(); req_valid = 1'b0; #1;
    checks++;
    if (st !== 4'b0000) begin errors++; $display("FAIL rmid_wait: got %b, want 0000", st); end
    #2 reset_n = 1'b0; #1;
    checks++;
    if ({st, wb_data, wb_rd, s_wb_data} !== {4'b0000, 32'h0, 5'h0, 32'h0}) begin
      errors++; $display("FAIL rmid_async: got st=%b data=%h rd=%0d sdata=%h, want 0000/0/0/0", st, wb_data, wb_rd, s_wb_data);
    end
    cyc(); reset_n = 1'b1; src_valid = 8'h20; src_data[5*32 +: 32] = 32'hFFFF_FFFF; #1;
    checks++;
    if (st !== 4'b0000) begin errors++; $display("FAIL rmid_release: got %b, want 0000", st); end
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      checks++;
      if ({st, wb_data} !== {4'b0100, 32'h0}) begin
        errors++; $display("FAIL rmid_nowb%0d: got st=%b data=%h, want 0100/0", k, st, wb_data);
      end
    end
    src_valid = 8'h00;
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_wait();
    test_timeout();
    test_priority();
    test_badsel();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
